pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/cache_types.sv | 18 +
 rtl/pmem_beat_ctr.sv | 29 ++
 rtl/pmem_responder.sv | 130 +++++++++++++
 tb/tb_pmem_responder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared cache/memory types: line and word types, responder FSM states,
// and the default number of 16-bit beats per line.
package cache_types;

    localparam int LINE_WORDS_DEFAULT = 8;
    localparam int WORD_W             = 16;

    typedef logic [WORD_W-1:0]                    word_t;
    typedef logic [WORD_W*LINE_WORDS_DEFAULT-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESPOND
    } state_t;

endpackage

// File: rtl/pmem_beat_ctr.sv
// Beat counter for line bursts: synchronous clear, increment on accepted beat,
// wraps to zero after the final beat, flags the final beat.
module pmem_beat_ctr
    import cache_types::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter int BW         = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [BW-1:0] beat,
    output logic          last
);

    assign last = (beat == BW'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (clr || (inc && last)) begin
            beat <= '0;
        end else if (inc) begin
            beat <= beat + 1'b1;
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// Cache line <-> 16-bit beat memory bridge. Optional PMEM_POSTED_WRITE_EN
// acknowledges writes right after acceptance and drains the burst in background.
module pmem_responder
    import cache_types::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter int ADDR_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pmem_read,
    input  logic                         pmem_write,
    input  logic [ADDR_W-1:0]            pmem_address,
    input  logic [WORD_W*LINE_WORDS-1:0] pmem_wdata,
    output logic [WORD_W*LINE_WORDS-1:0] pmem_rdata,
    output logic                         pmem_resp,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic [WORD_W-1:0]            mem_rdata,
    input  logic                         mem_ready
);

    localparam int BW     = $clog2(LINE_WORDS);
    localparam int LINE_W = WORD_W * LINE_WORDS;

    state_t              state, state_nxt;
    logic [ADDR_W-5:0]   line_q;
    logic [LINE_W-1:0]   wline_q;
    logic [LINE_W-1:0]   rline_q;
    logic [BW-1:0]       beat;
    logic                beat_last;
    logic                beat_clr;
    logic                beat_inc;
    logic                accept;
    logic                addr_lsb_unused;

    // Byte offset within a line carries no information for whole-line transfers.
    assign addr_lsb_unused = ^pmem_address[3:0];

    pmem_beat_ctr #(
        .LINE_WORDS (LINE_WORDS),
        .BW         (BW)
    ) u_beat_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (beat_clr),
        .inc   (beat_inc),
        .beat  (beat),
        .last  (beat_last)
    );

    always_comb begin
        state_nxt = state;
        beat_clr  = 1'b0;
        beat_inc  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (pmem_write) begin
                    state_nxt = WR_BURST;
                    beat_clr  = 1'b1;
                    accept    = 1'b1;
                end else if (pmem_read) begin
                    state_nxt = RD_BURST;
                    beat_clr  = 1'b1;
                    accept    = 1'b1;
                end
            end
            RD_BURST: begin
                if (mem_ready) begin
                    beat_inc = 1'b1;
                    if (beat_last) state_nxt = RESPOND;
                end
            end
            WR_BURST: begin
                if (mem_ready) begin
                    beat_inc = 1'b1;
`ifdef PMEM_POSTED_WRITE_EN
                    if (beat_last) state_nxt = IDLE;
`else
                    if (beat_last) state_nxt = RESPOND;
`endif
                end
            end
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            line_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                line_q <= pmem_address[ADDR_W-1:4];
                if (pmem_write) wline_q <= pmem_wdata;
            end
            if (state == RD_BURST && mem_ready) begin
                rline_q[WORD_W*beat +: WORD_W] <= mem_rdata;
            end
        end
    end

`ifdef PMEM_POSTED_WRITE_EN
    // Write acknowledge fires in the first drain cycle, independent of the burst.
    logic posted_resp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) posted_resp_q <= 1'b0;
        else        posted_resp_q <= accept && pmem_write;
    end

    assign pmem_resp = (state == RESPOND) || posted_resp_q;
`else
    assign pmem_resp = (state == RESPOND);
`endif

    assign pmem_rdata = rline_q;
    assign mem_rd     = (state == RD_BURST);
    assign mem_wr     = (state == WR_BURST);
    assign mem_addr   = {line_q, beat, 1'b0};
    assign mem_wdata  = wline_q[WORD_W*beat +: WORD_W];

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: behavioural line store plus randomized
// beat-side memory; expected beats and responses queued at stimulus time.
module tb_pmem_responder;

    localparam int LW = 8;
    localparam int AW = 16;
    localparam int LB = 16 * LW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pmem_read = 1'b0;
    logic          pmem_write = 1'b0;
    logic [AW-1:0] pmem_address = '0;
    logic [LB-1:0] pmem_wdata = '0;
    logic [LB-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata = '0;
    logic          mem_ready = 1'b0;

    pmem_responder #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } beat_t;

    typedef struct {
        logic          wr;
        logic [LB-1:0] line;
    } resp_t;

    beat_t         beat_q[$];
    resp_t         resp_q[$];
    logic [LB-1:0] ref_line [logic [11:0]];
    logic [15:0]   bmem [logic [AW-1:0]];

    int n_chk = 0;
    int n_pass = 0;
    int ready_mode = 0;
    int resp_cnt = 0;
    int wr_beats = 0;
    int last_resp_cyc = 0;
    int first_rd_cyc = -1;

    function automatic int now_c();
        return int'($time / 10);
    endfunction

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int k);
        logic [2:0] kk;
        kk = k[2:0];
        return {a[AW-1:4], kk, 1'b0};
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [LB-1:0] line);
        for (int k = 0; k < LW; k++) bmem[beat_addr(a, k)] = line[16*k +: 16];
        ref_line[a[AW-1:4]] = line;
    endtask

    // Beat-side memory model and beat monitor; ready is decided at the negedge
    // so a beat is known to complete at the following posedge.
    logic          prev_req = 1'b0;
    logic          prev_rdy = 1'b0;
    logic          prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [15:0]   prev_wd = '0;
    logic          alt = 1'b0;

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            prev_req  = 1'b0;
            mem_ready = 1'b0;
        end else begin
            if (mem_rd || mem_wr) chk("rd_wr_exclusive", LB'(mem_rd & mem_wr), '0);
            if (mem_rd && first_rd_cyc < 0) first_rd_cyc = now_c();
            if (prev_req && !prev_rdy) begin
                chk("stall_addr", LB'(mem_addr), LB'(prev_addr));
                chk("stall_kind", LB'({mem_rd, mem_wr}), LB'({~prev_wr, prev_wr}));
                if (prev_wr) chk("stall_wdata", LB'(mem_wdata), LB'(prev_wd));
            end
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       begin alt = ~alt; mem_ready = alt; end
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            mem_rdata = 16'hDEAD;
            if (mem_rd && bmem.exists(mem_addr)) mem_rdata = bmem[mem_addr];
            if ((mem_rd || mem_wr) && mem_ready) begin
                if (beat_q.size() == 0) begin
                    chk("beat_unexpected", LB'(mem_addr), '1);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_kind", LB'(mem_wr), LB'(b.wr));
                    chk("beat_addr", LB'(mem_addr), LB'(b.addr));
                    if (mem_wr) begin
                        chk("beat_wdata", LB'(mem_wdata), LB'(b.data));
                        bmem[mem_addr] = mem_wdata;
                        wr_beats++;
                    end
                end
            end
            prev_req  = mem_rd || mem_wr;
            prev_rdy  = mem_ready;
            prev_wr   = mem_wr;
            prev_addr = mem_addr;
            prev_wd   = mem_wdata;
        end
    end

    // Response monitor.
    logic prev_resp = 1'b0;

    always @(negedge clk) begin
        resp_t r;
        if (rst_n && pmem_resp) begin
            chk("resp_single_cycle", LB'(prev_resp), '0);
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", LB'(pmem_resp), '0);
            end else begin
                r = resp_q.pop_front();
                if (!r.wr) chk("pmem_rdata", pmem_rdata, r.line);
            end
            resp_cnt++;
            last_resp_cyc = now_c();
        end
        prev_resp = rst_n && pmem_resp;
    end

    // rdm: 0 no read, 1 read held together with the write, 2 read raised on the write's resp.
    task automatic txn(input bit wr, input int rdm, input logic [AW-1:0] addr,
                       input logic [LB-1:0] wline, output int lat);
        int t0, base, need, wresp;
        resp_t r;
        beat_t b;
        t0 = now_c();
        base = resp_cnt;
        need = 0;
        wresp = -1;
        first_rd_cyc = -1;
        if (wr) begin
            ref_line[addr[AW-1:4]] = wline;
            r.wr = 1'b1; r.line = '0;
            resp_q.push_back(r);
            for (int k = 0; k < LW; k++) begin
                b.wr = 1'b1; b.addr = beat_addr(addr, k); b.data = wline[16*k +: 16];
                beat_q.push_back(b);
            end
            need++;
        end
        if (rdm != 0) begin
            r.wr = 1'b0; r.line = ref_line[addr[AW-1:4]];
            resp_q.push_back(r);
            for (int k = 0; k < LW; k++) begin
                b.wr = 1'b0; b.addr = beat_addr(addr, k); b.data = '0;
                beat_q.push_back(b);
            end
            need++;
        end
        pmem_address = addr;
        pmem_wdata   = wline;
        pmem_write   = wr;
        pmem_read    = (rdm == 1) || (!wr && rdm != 0);
        for (int i = 0; i < 400 && (resp_cnt - base) < need; i++) begin
            @(negedge clk); #1;
            if (i == 0 && rdm == 0) begin
                pmem_address = ~addr;
                pmem_wdata   = ~wline;
            end
            if (pmem_resp) begin
                if (pmem_write) begin
                    pmem_write = 1'b0;
                    wresp = now_c();
                    if (rdm == 2) pmem_read = 1'b1;
                end else begin
                    pmem_read = 1'b0;
                end
            end
        end
        chk("resp_count", LB'(resp_cnt - base), LB'(need));
        if (wr && rdm != 0) chk("idle_gap_before_read", LB'(first_rd_cyc - wresp), LB'(2));
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        lat = last_resp_cyc - t0;
        @(negedge clk); #1;
    endtask

    function automatic logic [LB-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [AW-1:0] bases [5] = '{16'h1230, 16'h2000, 16'h3000, 16'h4000, 16'h5000};

    initial begin
        int lat;
        int w0;
        logic [LB-1:0] l;

        #1;
        chk("rst_pmem_resp", LB'(pmem_resp), '0);
        chk("rst_mem_rd", LB'(mem_rd), '0);
        chk("rst_mem_wr", LB'(mem_wr), '0);
        chk("rst_mem_addr", LB'(mem_addr), '0);
        chk("rst_mem_wdata", LB'(mem_wdata), '0);
        chk("rst_pmem_rdata", pmem_rdata, '0);

        for (int k = 0; k < LW; k++) l[16*k +: 16] = 16'(k);
        preload(16'h1230, l);
        for (int j = 1; j < 5; j++) preload(bases[j], rnd_line());

        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // Read with ready tied high: words 0..7, resp LINE_WORDS+1 cycles after acceptance.
        ready_mode = 0;
        txn(1'b0, 1, 16'h1230, '0, lat);
        chk("read_latency", LB'(lat), LB'(LW + 1));

        // Write with ready on alternate cycles.
        ready_mode = 1;
        for (int k = 0; k < LW; k++) l[16*k +: 16] = 16'hA00 + 16'(k);
        w0 = wr_beats;
        txn(1'b1, 0, 16'h4000, l, lat);
        chk("write_beat_count", LB'(wr_beats - w0), LB'(LW));
        txn(1'b0, 1, 16'h4007, '0, lat);

        // Simultaneous write and read: write first, then read.
        ready_mode = 2;
        txn(1'b1, 1, 16'h3000, rnd_line(), lat);

        // Write then read of the same line.
        ready_mode = 0;
        txn(1'b1, 2, 16'h2000, rnd_line(), lat);

        // Reset in the middle of a read burst.
        ready_mode = 0;
        w0 = resp_cnt;
        for (int k = 0; k < LW; k++) begin
            beat_t b;
            b.wr = 1'b0; b.addr = beat_addr(16'h5000, k); b.data = '0;
            beat_q.push_back(b);
        end
        pmem_address = 16'h5000;
        pmem_read = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pmem_resp", LB'(pmem_resp), '0);
        chk("midrst_mem_rd", LB'(mem_rd), '0);
        chk("midrst_mem_addr", LB'(mem_addr), '0);
        chk("midrst_mem_wdata", LB'(mem_wdata), '0);
        chk("midrst_pmem_rdata", pmem_rdata, '0);
        beat_q.delete();
        pmem_read = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("midrst_no_resp", LB'(resp_cnt - w0), '0);
        txn(1'b0, 1, 16'h5000, '0, lat);
        chk("post_reset_read_latency", LB'(lat), LB'(LW + 1));

        // Randomized mix.
        for (int i = 0; i < 12; i++) begin
            bit wr;
            int rdm;
            logic [AW-1:0] a;
            wr  = 1'($urandom_range(0, 1));
            rdm = int'($urandom_range(0, 2));
            if (!wr && rdm == 0) rdm = 1;
            a = bases[$urandom_range(0, 4)] | AW'($urandom_range(0, 15));
            ready_mode = int'($urandom_range(0, 2));
            txn(wr, rdm, a, rnd_line(), lat);
            if (ready_mode == 0 && !wr) chk("rand_read_latency", LB'(lat), LB'(LW + 1));
        end

        chk("beat_queue_drained", LB'(beat_q.size()), '0);
        chk("resp_queue_drained", LB'(resp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
